// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : UART receive front end. Synchronises the serial pad, decodes
//             8N1 frames with 16x oversampling and queues received bytes in
//             a small show-ahead FIFO drained through a valid/ready handshake.
//  Ports    : clk        - single clock, rising edge
//             reset      - asynchronous, active-high reset
//             uart_rx    - asynchronous serial line, idle high
//             rx_data    - FIFO head byte (meaningful while rx_valid)
//             rx_valid   - FIFO non-empty
//             rx_ready   - consumer accepts head byte on rx_valid & rx_ready
//             frame_err  - one-cycle pulse, stop bit sampled low
//             overrun    - one-cycle pulse, good byte dropped on full FIFO
//             fifo_count - current FIFO occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DIV        = 54,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int          c_addr_w  = $clog2(FIFO_DEPTH);
    localparam int          c_cnt_w   = c_addr_w + 1;
    localparam logic [15:0] c_div_last = 16'(DIV - 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    logic        s1_q, s2_q;
    state_t      state_q, state_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [3:0]  smp_q, smp_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        frame_err_q, overrun_q;

    logic        w_tick;
    logic        w_bit_end;
    logic        w_push;
    logic        w_ferr;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [c_addr_w-1:0] rd_ptr_q, wr_ptr_q;
    logic [c_cnt_w-1:0]  count_q;

    logic w_rx_valid;
    logic w_pop;
    logic w_full;
    logic w_wr_en;
    logic w_ovr;

    assign w_tick = (div_cnt_q == c_div_last);

    // ------------------------------------------------------------------
    // Frame decoder: next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        w_bit_end = 1'b0;
        w_push    = 1'b0;
        w_ferr    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!s2_q) state_d = ST_START;
            end
            ST_START: begin
                bit_cnt_d = 3'd0;
                // Mid start bit: a line that has already returned high was a glitch.
                if (w_tick && smp_q == 4'd7) state_d = s2_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_tick && smp_q == 4'd15) begin
                    w_bit_end = 1'b1;
                    shift_d   = {s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick && smp_q == 4'd15) begin
                    if (s2_q) begin
                        w_push  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        w_ferr  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // Hold off until the line is released so a break is one error.
                if (s2_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q || w_bit_end) smp_d = 4'd0;
        else if (w_tick)                     smp_d = smp_q + 4'd1;
        else                                 smp_d = smp_q;

        if (state_d != state_q || state_q == ST_IDLE ||
            state_q == ST_WAIT_IDLE || w_tick)
            div_cnt_d = 16'd0;
        else
            div_cnt_d = div_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            state_q     <= ST_IDLE;
            div_cnt_q   <= 16'd0;
            smp_q       <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            s1_q        <= uart_rx;
            s2_q        <= s1_q;
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            smp_q       <= smp_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= w_ferr;
            overrun_q   <= w_ovr;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    assign w_rx_valid = (count_q != '0);
    assign w_pop      = w_rx_valid & rx_ready;
    assign w_full     = (count_q == c_depth);
    // When full, a simultaneous pop frees the head slot, which is exactly
    // the slot the write pointer addresses, so the push can still land.
    assign w_wr_en    = w_push & (~w_full | w_pop);
    assign w_ovr      = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_wr_en) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + c_addr_w'(1);
            end
            if (w_pop) rd_ptr_q <= rd_ptr_q + c_addr_w'(1);
            case ({w_wr_en, w_pop})
                2'b10:   count_q <= count_q + c_cnt_w'(1);
                2'b01:   count_q <= count_q - c_cnt_w'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rx_data    = mem_q[rd_ptr_q];
    assign rx_valid   = w_rx_valid;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Purpose  : Self-checking bench for uart_rx_fifo (DIV=4, FIFO_DEPTH=4).
//             Table of single frames plus hand-written corner sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int BIT   = 16 * DIV;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       uart_rx  = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic [2:0] fifo_count;

    int n_cmp    = 0;
    int n_bad    = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int both_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       stopb;
        logic       exp_push;
        int         exp_ferr;
    } vec_t;

    vec_t tbl [8];

    uart_rx_fifo #(.DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (frame_err && overrun) both_cnt++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge with the line idle.
    task automatic send_frame(input logic [7:0] b, input logic stopb);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = stopb;
        repeat (BIT) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic drain_check(input string nm, input logic [7:0] exp);
        check({nm, "_valid"}, {31'd0, rx_valid}, 32'd1);
        check({nm, "_data"}, {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int o0;

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 0};
        tbl[1] = '{8'h3C, 1'b1, 1'b1, 0};
        tbl[2] = '{8'h00, 1'b1, 1'b1, 0};
        tbl[3] = '{8'hFF, 1'b1, 1'b1, 0};
        tbl[4] = '{8'h55, 1'b0, 1'b0, 1};
        tbl[5] = '{8'h0F, 1'b1, 1'b1, 0};
        tbl[6] = '{8'h81, 1'b0, 1'b0, 1};
        tbl[7] = '{8'h7E, 1'b1, 1'b1, 0};

        // Reset values
        idle(2);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        idle(1000);
        check("idle_valid", {31'd0, rx_valid}, 32'd0);
        check("idle_ferr", ferr_cnt, 0);
        check("idle_ovr", ovr_cnt, 0);

        // Single frame latency: push lands at E0+610 (= E2+608)
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (610) @(posedge clk);
                @(negedge clk);
                check("lat_before", {31'd0, rx_valid}, 32'd0);
                @(posedge clk);
                @(negedge clk);
                check("lat_valid", {31'd0, rx_valid}, 32'd1);
                check("lat_data", {24'd0, rx_data}, 32'hA5);
                check("lat_count", {29'd0, fifo_count}, 32'd1);
            end
        join
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("pop_valid", {31'd0, rx_valid}, 32'd0);
        check("pop_count", {29'd0, fifo_count}, 32'd0);

        // Table of single frames
        for (int i = 0; i < 8; i++) begin
            f0 = ferr_cnt;
            send_frame(tbl[i].data, tbl[i].stopb);
            idle(BIT);
            check($sformatf("tbl%0d_count", i), {29'd0, fifo_count}, {31'd0, tbl[i].exp_push});
            check($sformatf("tbl%0d_ferr", i), ferr_cnt - f0, tbl[i].exp_ferr);
            if (tbl[i].exp_push) begin
                drain_check($sformatf("tbl%0d", i), tbl[i].data);
                check($sformatf("tbl%0d_empty", i), {29'd0, fifo_count}, 32'd0);
            end
        end

        // False start
        f0 = ferr_cnt;
        uart_rx = 1'b0;
        idle(12);
        uart_rx = 1'b1;
        idle(2 * BIT);
        check("fs_count", {29'd0, fifo_count}, 32'd0);
        check("fs_ferr", ferr_cnt - f0, 0);
        send_frame(8'h3C, 1'b1);
        idle(BIT);
        check("fs_next_count", {29'd0, fifo_count}, 32'd1);
        drain_check("fs_next", 8'h3C);

        // Framing error followed by a break
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        uart_rx = 1'b0;
        idle(5 * BIT);
        check("brk_ferr", ferr_cnt - f0, 1);
        check("brk_count", {29'd0, fifo_count}, 32'd0);
        uart_rx = 1'b1;
        idle(BIT);
        send_frame(8'h0F, 1'b1);
        idle(BIT);
        check("brk_next_count", {29'd0, fifo_count}, 32'd1);
        check("brk_ferr_once", ferr_cnt - f0, 1);
        drain_check("brk_next", 8'h0F);

        // Overrun on the fifth back-to-back byte
        o0 = ovr_cnt;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        idle(BIT);
        check("ovr_count", {29'd0, fifo_count}, 32'd4);
        check("ovr_pulse", ovr_cnt - o0, 1);
        for (int i = 1; i <= 4; i++) drain_check($sformatf("ovr_drain%0d", i), 8'(i));
        check("ovr_empty", {29'd0, fifo_count}, 32'd0);

        // Full FIFO with a pop exactly on the stop-sample cycle
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        check("fp_pre_count", {29'd0, fifo_count}, 32'd4);
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (610) @(posedge clk);
                @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                check("fp_count_at", {29'd0, fifo_count}, 32'd4);
            end
        join
        idle(BIT);
        check("fp_count", {29'd0, fifo_count}, 32'd4);
        check("fp_ovr", ovr_cnt - o0, 0);
        drain_check("fp_d0", 8'h22);
        drain_check("fp_d1", 8'h33);
        drain_check("fp_d2", 8'h44);
        drain_check("fp_d3", 8'h77);

        // rx_ready while empty does nothing
        rx_ready = 1'b1;
        idle(5);
        rx_ready = 1'b0;
        check("empty_rdy_count", {29'd0, fifo_count}, 32'd0);
        check("empty_rdy_valid", {31'd0, rx_valid}, 32'd0);

        // Asynchronous reset mid-frame with data queued
        f0 = ferr_cnt;
        send_frame(8'h5A, 1'b1);
        send_frame(8'hC3, 1'b1);
        check("mr_pre_count", {29'd0, fifo_count}, 32'd2);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                idle(300);
                #3;
                reset = 1'b1;
                #1;
                check("mr_valid", {31'd0, rx_valid}, 32'd0);
                check("mr_count", {29'd0, fifo_count}, 32'd0);
                check("mr_data", {24'd0, rx_data}, 32'd0);
                check("mr_ferr", {31'd0, frame_err}, 32'd0);
                @(negedge clk);
                reset = 1'b0;
            end
        join
        idle(2 * BIT);
        check("mr_post_count", {29'd0, fifo_count}, 32'd0);
        check("mr_post_ferr", ferr_cnt - f0, 0);

        check("never_both", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receive front end for the SoC: samples the asynchronous `uart_rx` pad, decodes 8N1 frames with 16x oversampling, and buffers received bytes in a small show-ahead FIFO. It sits between the top-level `uart_rx` pin and the APB UART register block. The register block drains bytes through a valid/ready handshake and observes framing and overrun error pulses.

## Interface
- `DIV`, default 54: `clk` cycles per oversample tick. Baud = f_clk / (16*DIV). Legal range is 2..65535.
- `FIFO_DEPTH`, default 4: receive FIFO entries. Must be a power of two, at least 2.
- `clk` input, 1 bit: single clock for all logic, rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `uart_rx` input, 1 bit: serial line, asynchronous, idle high.
- `rx_data` output, 8 bits: FIFO head byte. Valid only while `rx_valid` = 1.
- `rx_valid` output, 1 bit: FIFO non-empty.
- `rx_ready` input, 1 bit: consumer accepts the head byte when `rx_valid & rx_ready`.
- `frame_err` output, 1 bit: one-cycle pulse when a stop bit is sampled as 0.
- `overrun` output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `fifo_count` output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.

## Operation
- **Synchronizer:** `uart_rx` passes through 2 flops (`s1`, `s2`). Both reset to 1. All decoding uses `s2`.
- **Tick generator:** `div_cnt` counts 0..DIV-1 and asserts `tick` while `div_cnt == DIV-1`. It is forced to 0 in IDLE and WAIT_IDLE, and on every state change.
- **Sample counter:** `smp` is 4 bits. It increments on `tick` and clears on every state change and every bit boundary.
- **FSM** (resets to IDLE):
  - IDLE: if `s2 == 0`, go to START.
  - START: on `tick` with `smp == 7` (mid start bit), go to DATA if `s2 == 0`. Otherwise it is a false start; return to IDLE and push nothing.
  - DATA: on `tick` with `smp == 15`, shift `s2` into the shift register, LSB first. After the 8th bit, go to STOP.
  - STOP: on `tick` with `smp == 15`:
    - If `s2 == 1`, push the byte and go to IDLE.
    - If `s2 == 0`, pulse `frame_err`, drop the byte, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `s2 == 1`, then go to IDLE. This prevents a held-low break from producing repeated frames.
- **FIFO:** circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits that wrap naturally.
  - `rx_data` is `mem[rd_ptr]`, combinational from registered state.
  - `rx_valid` is `fifo_count != 0`.
  - Pop occurs on `rx_valid & rx_ready`. `rx_ready` while empty has no effect.
- **Push rules:**
  - FIFO not full: the byte is written and the count increments, unless a pop happens in the same cycle, in which case the count is unchanged.
  - FIFO full with a simultaneous pop: the push is accepted and the count stays at FIFO_DEPTH.
  - FIFO full without a pop: the byte is dropped, `overrun` pulses, and the FIFO contents are unchanged.
- `frame_err` and `overrun` never assert in the same cycle.

## Timing
- **Reset values:** `rx_valid` = 0, `fifo_count` = 0, `frame_err` = 0, `overrun` = 0, `rx_data` = 8'h00 (memory cleared), FSM = IDLE, `s1`/`s2` = 1.
- Reset asserted mid-frame aborts the frame immediately with no push and no error pulse.
- **Frame latency:** take E0 as the clock edge that first captures `uart_rx` = 0 into `s1`.
  - FSM enters START at E2.
  - Tick k occurs at edge E2 + k*DIV.
  - The start bit is checked at tick 8. Data bit n (0..7) is sampled at tick 24+16n. The stop bit is sampled at tick 152.
  - The push lands at edge E2 + 152*DIV, and `rx_valid` is 1 after that edge.
  - The error pulses are registered outputs, high for the one cycle following the stop-sample edge.
- FSM returns to IDLE at the stop-sample edge, so a new start bit is accepted from half a bit-time onward (back-to-back frames supported).
- **Pop timing:** `rx_data` and `fifo_count` update on the edge after a handshake. Throughput is 1 byte per cycle.

## Test plan
- **Reset:** assert `reset` asynchronously between edges. All outputs go to their reset values immediately. Hold `uart_rx` = 1 for 1000 cycles, then check no `rx_valid` and no error pulses.
- **Single frame (DIV=4):** send 8'hA5 with `rx_ready` = 0. `rx_valid` rises at E2+608, `rx_data` = 8'hA5, `fifo_count` = 1. Raise `rx_ready`; on the next edge `rx_valid` = 0 and `fifo_count` = 0.
- **False start:** drive `uart_rx` low for 12 cycles (< half bit at DIV=4), then high. No push, no `frame_err`, FSM back in IDLE. A following 8'h3C is received correctly.
- **Framing error and break:** send 8'h55 with stop bit = 0, then hold the line low for 5 bit-times. Exactly one `frame_err` pulse, no push. After the line returns high, 8'h0F is received correctly.
- **Overrun:** send 5 back-to-back bytes 8'h01..8'h05 with `rx_ready` = 0 and FIFO_DEPTH = 4. `fifo_count` = 4 and one `overrun` pulse on byte 5. Draining yields 01, 02, 03, 04.
- **Full with simultaneous pop:** with 4 bytes queued, assert `rx_ready` for exactly the stop-sample cycle of byte 8'h77. No `overrun`, `fifo_count` stays 4, and the drain order ends with 8'h77.
